// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment vectors are ordered g..a (bit0 = a). The font is active-high;
// polarity is applied in seg7_glyph.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  // Active-high "all segments off".
  localparam seg_t SEG_OFF = 7'h00;

  // Standard hex font: 0-9, A, b, C, d, E, F (active-high, bit0 = a).
  localparam seg_t FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    DEAD  = 1'b0,
    DRIVE = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_glyph.sv
// Combinational glyph generator: nibble + blank + dp -> pin-polarity segments.
// Ports:
//   nibble  hex value to render
//   blank   1 = segments dark (dp is still honoured)
//   dp      decimal point enable
//   seg_c   segments g..a in pin polarity
//   dp_c    decimal point in pin polarity
module seg7_glyph
  import seg7_pkg::*;
#(
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dp,
  output seg_t       seg_c,
  output logic       dp_c
);

  seg_t seg_raw;

  // Font lookup, then polarity.
  always_comb begin
    seg_raw = blank ? SEG_OFF : FONT[nibble];
    seg_c   = (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    dp_c    = (ACTIVE_LOW != 0) ? ~dp : dp;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed NDIGITS seven-segment driver with tear-free updates,
// inter-digit dead time, blanking, decimal points and leading-zero suppression.
// Optional macro SEG7_SCAN_DIM_EN adds bright_in[3:0] (PWM dimming inside the
// DRIVE window, sampled at the frame boundary).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   wr_en               strobe capturing wr_data/dp_in/blank_in into pending
//   wr_data             hex nibbles, nibble 0 = rightmost digit
//   dp_in, blank_in     per-digit decimal point / force-dark
//   lz_en               leading-zero suppression (live)
//   bright_in           brightness 0..15 (SEG7_SCAN_DIM_EN only)
//   seg_o, dp_o, an_o   display pins (registered, polarity ACTIVE_LOW)
//   frame_o             one-cycle pulse on the first DEAD cycle of a frame
//   pend_o              pending data not yet committed to shadow
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NDIGITS    = 6,
  parameter int unsigned DIV        = 50000,
  parameter int unsigned DEAD_CYC   = 64,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [4*NDIGITS-1:0]   wr_data,
  input  logic [NDIGITS-1:0]     dp_in,
  input  logic [NDIGITS-1:0]     blank_in,
  input  logic                   lz_en,
`ifdef SEG7_SCAN_DIM_EN
  input  logic [3:0]             bright_in,
`endif
  output seg_t                   seg_o,
  output logic                   dp_o,
  output logic [NDIGITS-1:0]     an_o,
  output logic                   frame_o,
  output logic                   pend_o
);

  localparam int unsigned MAXC  = (DIV > DEAD_CYC) ? DIV : DEAD_CYC;
  localparam int unsigned CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int unsigned IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  localparam logic                AL_BIT   = (ACTIVE_LOW != 0);
  localparam logic [NDIGITS-1:0]  AN_OFF   = {NDIGITS{AL_BIT}};
  localparam seg_t                SEG_INACT = {7{AL_BIT}};

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 boundary_c;

  logic [4*NDIGITS-1:0] pend_data, shad_data;
  logic [NDIGITS-1:0]   pend_dp, pend_blank, shad_dp, shad_blank;

  logic                 lit_c;
  logic                 supp_c;
  logic [3:0]           nib_c;
  seg_t                 glyph_seg_c;
  logic                 glyph_dp_c;
  logic [NDIGITS-1:0]   an_c;
  seg_t                 seg_c;
  logic                 dp_c;
  logic                 frame_c;

  // Scan state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DEAD;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Scan next-state: DEAD_CYC dark cycles, then DIV cycles driving idx.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    boundary_c = 1'b0;
    case (state_q)
      DEAD: begin
        if (cnt_q == CNT_W'(DEAD_CYC - 1)) begin
          state_d = DRIVE;
          cnt_d   = '0;
        end
      end
      DRIVE: begin
        if (cnt_q == CNT_W'(DIV - 1)) begin
          state_d = DEAD;
          cnt_d   = '0;
          if (idx_q == IDX_W'(NDIGITS - 1)) begin
            idx_d      = '0;
            boundary_c = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = DEAD;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Pending/shadow pair; shadow only changes on the frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      shad_data  <= '0;
      shad_dp    <= '0;
      shad_blank <= '0;
      pend_o     <= 1'b0;
    end else if (boundary_c) begin
      if (wr_en) begin
        shad_data  <= wr_data;
        shad_dp    <= dp_in;
        shad_blank <= blank_in;
      end else if (pend_o) begin
        shad_data  <= pend_data;
        shad_dp    <= pend_dp;
        shad_blank <= pend_blank;
      end
      pend_o <= 1'b0;
    end else if (wr_en) begin
      pend_data  <= wr_data;
      pend_dp    <= dp_in;
      pend_blank <= blank_in;
      pend_o     <= 1'b1;
    end
  end

`ifdef SEG7_SCAN_DIM_EN
  logic [3:0] bright_q;

  // Brightness is frame-synchronous like the display data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bright_q <= 4'hF;
    end else if (boundary_c) begin
      bright_q <= bright_in;
    end
  end

  // Lit for the first ((bright+1)*DIV)/16 cycles of the DRIVE window.
  always_comb begin
    lit_c = (32'(cnt_q) < (((32'(bright_q) + 32'd1) * 32'(DIV)) >> 4));
  end
`else
  always_comb begin
    lit_c = 1'b1;
  end
`endif

  // Current digit select; suppressed when it and every digit above it are 0.
  always_comb begin
    nib_c  = shad_data[{idx_q, 2'b00} +: 4];
    supp_c = lz_en && (idx_q != '0) && ((shad_data >> {idx_q, 2'b00}) == '0);
  end

  seg7_glyph #(
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_glyph (
    .nibble (nib_c),
    .blank  (shad_blank[idx_q] | supp_c),
    .dp     (shad_dp[idx_q]),
    .seg_c  (glyph_seg_c),
    .dp_c   (glyph_dp_c)
  );

  // Pin values for the current scan state; inactive unless driving and lit.
  always_comb begin
    an_c    = AN_OFF;
    seg_c   = SEG_INACT;
    dp_c    = AL_BIT;
    frame_c = (state_q == DEAD) && (cnt_q == '0) && (idx_q == '0);
    if ((state_q == DRIVE) && lit_c) begin
      an_c  = (NDIGITS'(1) << idx_q) ^ AN_OFF;
      seg_c = glyph_seg_c;
      dp_c  = glyph_dp_c;
    end
  end

  // Output pins: one cycle behind the scan state, dark while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_o    <= AN_OFF;
      seg_o   <= SEG_INACT;
      dp_o    <= AL_BIT;
      frame_o <= 1'b0;
    end else begin
      an_o    <= an_c;
      seg_o   <= seg_c;
      dp_o    <= dp_c;
      frame_o <= frame_c;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (NDIGITS=6, DIV=4, DEAD_CYC=2,
// ACTIVE_LOW=1). A frame-position model predicts every pin each cycle.
module tb_seg7_scan_driver;

  localparam int NDIG  = 6;
  localparam int DIVP  = 4;
  localparam int DEADP = 2;
  localparam int SLOT  = DIVP + DEADP;
  localparam int FRAME = NDIG * SLOT;

  localparam logic [6:0] FONT_TB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [23:0] wr_data;
  logic [5:0]  dp_in;
  logic [5:0]  blank_in;
  logic        lz_en;
`ifdef SEG7_SCAN_DIM_EN
  logic [3:0]  bright_in;
  int          m_bright;
`endif
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [5:0]  an_o;
  logic        frame_o;
  logic        pend_o;

  int          errors;
  int          checks;
  int          k;
  int          last_p;

  logic [23:0] m_sh, m_pd;
  logic [5:0]  m_shdp, m_shbl, m_pddp, m_pdbl;
  logic        m_pend;

  seg7_scan_driver #(
    .NDIGITS    (NDIG),
    .DIV        (DIVP),
    .DEAD_CYC   (DEADP),
    .ACTIVE_LOW (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .dp_in     (dp_in),
    .blank_in  (blank_in),
    .lz_en     (lz_en),
`ifdef SEG7_SCAN_DIM_EN
    .bright_in (bright_in),
`endif
    .seg_o     (seg_o),
    .dp_o      (dp_o),
    .an_o      (an_o),
    .frame_o   (frame_o),
    .pend_o    (pend_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", nm, got, exp, k);
    end
  endtask

  task automatic model_reset();
    k      = 0;
    last_p = -1;
    m_sh   = '0; m_pd   = '0;
    m_shdp = '0; m_shbl = '0;
    m_pddp = '0; m_pdbl = '0;
    m_pend = 1'b0;
`ifdef SEG7_SCAN_DIM_EN
    m_bright = 15;
`endif
  endtask

  // Pins expected after the edge that ends absolute cycle k.
  task automatic model_out(output logic [5:0] ean, output logic [6:0] eseg,
                           output logic edp, output logic efr);
    int p, d, w, c;
    logic lit, dark;
    logic [23:0] upper;
    logic [5:0] one;
    p    = k % FRAME;
    d    = p / SLOT;
    w    = p % SLOT;
    one  = 6'b000001;
    ean  = 6'h3F;
    eseg = 7'h7F;
    edp  = 1'b1;
    efr  = (p == 0);
    if (w >= DEADP) begin
      c   = w - DEADP;
      lit = 1'b1;
`ifdef SEG7_SCAN_DIM_EN
      lit = (c < ((m_bright + 1) * DIVP) / 16);
`endif
      if (lit) begin
        upper = m_sh >> (4 * d);
        dark  = m_shbl[d] || (lz_en && d != 0 && upper == 24'h0);
        ean   = ~(one << d);
        eseg  = dark ? 7'h7F : ~FONT_TB[upper[3:0]];
        edp   = ~m_shdp[d];
      end
    end
  endtask

  // One clock: predict, apply write/commit rules, advance, compare.
  task automatic run_cycle();
    logic [5:0] ean;
    logic [6:0] eseg;
    logic edp, efr;
    model_out(ean, eseg, edp, efr);
    if (k % FRAME == FRAME - 1) begin
`ifdef SEG7_SCAN_DIM_EN
      m_bright = int'(bright_in);
`endif
      if (wr_en) begin
        m_sh = wr_data; m_shdp = dp_in; m_shbl = blank_in;
      end else if (m_pend) begin
        m_sh = m_pd; m_shdp = m_pddp; m_shbl = m_pdbl;
      end
      m_pend = 1'b0;
    end else if (wr_en) begin
      m_pd = wr_data; m_pddp = dp_in; m_pdbl = blank_in;
      m_pend = 1'b1;
    end
    last_p = k % FRAME;
    k++;
    @(posedge clk);
    #1;
    chk("an_o",    32'(an_o),    32'(ean));
    chk("seg_o",   32'(seg_o),   32'(eseg));
    chk("dp_o",    32'(dp_o),    32'(edp));
    chk("frame_o", 32'(frame_o), 32'(efr));
    chk("pend_o",  32'(pend_o),  32'(m_pend));
    wr_en = 1'b0;
  endtask

  task automatic run_to(input int target);
    for (int n = 0; n <= FRAME; n++) begin
      run_cycle();
      if (last_p == target) return;
    end
    errors++;
    checks++;
    $display("FAIL run_to: position %0d not reached, last %0d", target, last_p);
  endtask

  // Write exactly on the frame-boundary cycle so it commits at once.
  task automatic boundary_write(input logic [23:0] d, input logic [5:0] dp,
                                input logic [5:0] bl);
    run_to(FRAME - 2);
    wr_data  = d;
    dp_in    = dp;
    blank_in = bl;
    wr_en    = 1'b1;
    run_cycle();
    chk("boundary_pend", 32'(pend_o), 32'd0);
  endtask

  task automatic rand_inputs();
    int lz;
    logic [23:0] mask;
    wr_en    = ($urandom_range(0, 7) == 0);
    lz       = $urandom_range(0, 6);
    mask     = 24'hFFFFFF >> (4 * lz);
    wr_data  = 24'($urandom) & mask;
    dp_in    = 6'($urandom);
    blank_in = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h00;
    if ($urandom_range(0, 29) == 0) lz_en = ~lz_en;
`ifdef SEG7_SCAN_DIM_EN
    bright_in = 4'($urandom);
`endif
  endtask

  initial begin
    int n;
    errors   = 0;
    checks   = 0;
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_data  = '0;
    dp_in    = '0;
    blank_in = '0;
    lz_en    = 1'b0;
`ifdef SEG7_SCAN_DIM_EN
    bright_in = 4'hF;
`endif
    model_reset();
    #1;
    chk("reset_an",  32'(an_o),  32'h3F);
    chk("reset_seg", 32'(seg_o), 32'h7F);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // First frame after reset: two dead cycles, then digit 0 shows '0'.
    run_cycle();
    chk("first_frame", 32'(frame_o), 32'd1);
    chk("first_dead_an", 32'(an_o), 32'h3F);
    run_cycle();
    run_cycle();
    chk("first_drive_an",  32'(an_o),  32'(6'b111110));
    chk("first_drive_seg", 32'(seg_o), 32'(7'b1000000));

    // Scan order and glyphs.
    boundary_write(24'h001234, 6'h00, 6'h00);
    run_to(DEADP);
    chk("d0_an",  32'(an_o),  32'(6'b111110));
    chk("d0_seg", 32'(seg_o), 32'(7'b0011001));
    run_to(SLOT + DEADP);
    chk("d1_an",  32'(an_o),  32'(6'b111101));
    run_to(3 * SLOT + DEADP);
    chk("d3_an",  32'(an_o),  32'(6'b110111));
    chk("d3_seg", 32'(seg_o), 32'(7'b1111001));
    run_to(5 * SLOT + DEADP);
    chk("d5_an",  32'(an_o),  32'(6'b011111));
    chk("d5_seg", 32'(seg_o), 32'(7'b1000000));

    // Frame period.
    run_to(0);
    chk("frame_pulse", 32'(frame_o), 32'd1);
    n = 0;
    do begin
      run_cycle();
      n++;
    end while (frame_o !== 1'b1 && n < 100);
    chk("frame_spacing", 32'(n), 32'd36);

    // Mid-frame write stays pending until the boundary.
    run_to(9);
    wr_data = 24'h00ABCD;
    wr_en   = 1'b1;
    run_cycle();
    chk("mid_pend", 32'(pend_o), 32'd1);
    run_to(3 * SLOT + DEADP);
    chk("old_d3_seg", 32'(seg_o), 32'(7'b1111001));
    run_to(0);
    chk("commit_pend", 32'(pend_o), 32'd0);
    run_to(DEADP);
    chk("new_d0_seg", 32'(seg_o), 32'(7'b0100001));

    // Leading-zero suppression.
    lz_en = 1'b1;
    boundary_write(24'h000050, 6'h00, 6'h00);
    run_to(DEADP);
    chk("lz_d0_seg", 32'(seg_o), 32'(7'b1000000));
    run_to(SLOT + DEADP);
    chk("lz_d1_seg", 32'(seg_o), 32'(7'b0010010));
    run_to(2 * SLOT + DEADP);
    chk("lz_d2_seg", 32'(seg_o), 32'h7F);
    chk("lz_d2_an",  32'(an_o),  32'(6'b111011));
    run_to(5 * SLOT + DEADP);
    chk("lz_d5_seg", 32'(seg_o), 32'h7F);
    boundary_write(24'h000000, 6'h00, 6'h00);
    run_to(DEADP);
    chk("zero_d0_seg", 32'(seg_o), 32'(7'b1000000));
    run_to(SLOT + DEADP);
    chk("zero_d1_seg", 32'(seg_o), 32'h7F);
    lz_en = 1'b0;
    run_to(5 * SLOT + DEADP);
    chk("nolz_d5_seg", 32'(seg_o), 32'(7'b1000000));

    // Blank with decimal point.
    boundary_write(24'h000000, 6'b000100, 6'b000100);
    run_to(2 * SLOT + DEADP);
    chk("blank_d2_seg", 32'(seg_o), 32'h7F);
    chk("blank_d2_dp",  32'(dp_o),  32'd0);
    run_to(3 * SLOT + DEADP);
    chk("d3_dp_off",    32'(dp_o),  32'd1);

`ifdef SEG7_SCAN_DIM_EN
    // bright=3 with DIV=4: one lit cycle per digit.
    bright_in = 4'd3;
    run_to(FRAME - 2);
    run_cycle();
    bright_in = 4'hF;
    run_to(DEADP);
    chk("dim_lit_an",  32'(an_o), 32'(6'b111110));
    run_cycle();
    chk("dim_dark_an", 32'(an_o), 32'h3F);
    run_to(FRAME - 2);
    run_cycle();
`endif

    // Reset in the middle of a DRIVE with a write pending.
    run_to(9);
    wr_data = 24'h654321;
    wr_en   = 1'b1;
    run_cycle();
    run_to(2 * SLOT + DEADP + 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_an",    32'(an_o),    32'h3F);
    chk("rst_seg",   32'(seg_o),   32'h7F);
    chk("rst_dp",    32'(dp_o),    32'd1);
    chk("rst_frame", 32'(frame_o), 32'd0);
    chk("rst_pend",  32'(pend_o),  32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run_cycle();
    run_cycle();
    chk("rst_dead_an", 32'(an_o), 32'h3F);
    run_cycle();
    chk("rst_drive_an", 32'(an_o), 32'(6'b111110));

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      rand_inputs();
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
